// File: rtl/sdram_cmd_arbiter.sv
// Four-port round-robin arbiter for the shared SDRAM command/address interface.
// Define ARB_WATCHDOG_EN to abort a command that never receives CMD_ACK and flag ERR.
module sdram_cmd_arbiter #(
  parameter int unsigned ASIZE    = 23,
  parameter int unsigned WDOG_CYC = 1023
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [3:0]           REQ,
  input  logic [3:0]           REQ_WR,
  input  logic [4*ASIZE-1:0]   REQ_ADDR,
  input  logic                 INIT_REQ,
  input  logic                 REF_REQ,
  input  logic                 CMD_ACK,
  output logic [2:0]           CMD,
  output logic [ASIZE-1:0]     ADDR,
  output logic [3:0]           ACK,
  output logic [1:0]           GRANT_ID,
  output logic                 BUSY,
  output logic                 ERR
);

  localparam int unsigned NPORT = 4;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_RECOVER = 2'd2;

  localparam logic [2:0] CMD_NOP    = 3'b000;
  localparam logic [2:0] CMD_READA  = 3'b001;
  localparam logic [2:0] CMD_WRITEA = 3'b010;

  // The watchdog counter is 16 bits wide, so the limit must fit in it.
  if (WDOG_CYC < 1 || WDOG_CYC > 65536) begin : g_wdog_range_chk
    $error("sdram_cmd_arbiter: WDOG_CYC must be in 1..65536");
  end

  logic [1:0]       state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [2:0]       cmd_q, cmd_d;
  logic [ASIZE-1:0] addr_q, addr_d;
  logic [3:0]       ack_q, ack_d;
  logic [1:0]       gid_q, gid_d;
  logic             busy_q, busy_d;

  logic [ASIZE-1:0] port_addr [NPORT];
  logic             pick_vld;
  logic [1:0]       pick_idx;
  logic [1:0]       cand;
  logic             grant_ok;

  for (genvar g = 0; g < int'(NPORT); g++) begin : g_port_addr
    assign port_addr[g] = REQ_ADDR[g*ASIZE +: ASIZE];
  end

  // Rotating priority search starting one past the last granted port.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = last_q;
    cand     = last_q;
    for (int k = 1; k <= int'(NPORT); k++) begin
      cand = last_q + 2'(k);
      if (!pick_vld && REQ[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign grant_ok = !INIT_REQ && !REF_REQ && pick_vld;

`ifdef ARB_WATCHDOG_EN
  localparam logic [15:0] WDOG_LIM = 16'(WDOG_CYC - 1);

  logic [15:0] wdog_q, wdog_d;
  logic        err_q, err_d;
  logic        wdog_hit;

  assign wdog_hit = (wdog_q == WDOG_LIM);
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    ack_d   = 4'b0000;
    gid_d   = gid_q;
    busy_d  = busy_q;
`ifdef ARB_WATCHDOG_EN
    wdog_d  = wdog_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant_ok) begin
          cmd_d   = REQ_WR[pick_idx] ? CMD_WRITEA : CMD_READA;
          addr_d  = port_addr[pick_idx];
          gid_d   = pick_idx;
          last_d  = pick_idx;
          busy_d  = 1'b1;
          state_d = S_ISSUE;
`ifdef ARB_WATCHDOG_EN
          wdog_d  = 16'd0;
`endif
        end
      end
      S_ISSUE: begin
        if (CMD_ACK) begin
          cmd_d        = CMD_NOP;
          ack_d[gid_q] = 1'b1;
          busy_d       = 1'b0;
          state_d      = S_RECOVER;
        end
`ifdef ARB_WATCHDOG_EN
        else if (wdog_hit) begin
          cmd_d   = CMD_NOP;
          busy_d  = 1'b0;
          err_d   = 1'b1;
          state_d = S_RECOVER;
        end else begin
          wdog_d  = wdog_q + 16'd1;
        end
`endif
      end
      S_RECOVER: begin
        state_d = S_IDLE;
      end
      default: begin
        cmd_d   = CMD_NOP;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Synchronous active-low reset; last_q=3 gives port 0 first priority.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      last_q  <= 2'd3;
      cmd_q   <= CMD_NOP;
      addr_q  <= '0;
      ack_q   <= 4'b0000;
      gid_q   <= 2'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      ack_q   <= ack_d;
      gid_q   <= gid_d;
      busy_q  <= busy_d;
    end
  end

`ifdef ARB_WATCHDOG_EN
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      wdog_q <= 16'd0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

  assign CMD      = cmd_q;
  assign ADDR     = addr_q;
  assign ACK      = ack_q;
  assign GRANT_ID = gid_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Scoreboard bench for sdram_cmd_arbiter: expected grants/ACKs are queued as
// stimulus is applied and popped by a negedge monitor when the DUT produces them.
module tb_sdram_cmd_arbiter;

  localparam int unsigned ASIZE    = 23;
  localparam int unsigned WDOG_CYC = 15;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req;
  logic [3:0] req_wr;
  logic [4*ASIZE-1:0] req_addr;
  logic init_req;
  logic ref_req;
  logic cmd_ack;
  logic [2:0] cmd;
  logic [ASIZE-1:0] addr;
  logic [3:0] ack;
  logic [1:0] gid;
  logic busy;
  logic err;

  typedef struct packed {
    logic [2:0]       cmd;
    logic [ASIZE-1:0] addr;
    logic [1:0]       gid;
  } grant_t;

  grant_t     exp_grant_q[$];
  logic [3:0] exp_ack_q[$];
  int         grant_cyc_q[$];

  logic [ASIZE-1:0] port_addr [4];
  int  n_checks  = 0;
  int  n_fail    = 0;
  int  cyc       = 0;
  int  issue_cyc = 0;
  int  ack_lat   = 1;
  bit  auto_ack  = 1'b1;
  bit  spur_ack  = 1'b0;
  logic [2:0] prev_cmd = 3'b000;
  grant_t     mon_g;
  logic [3:0] mon_a;

  always #5 clk = ~clk;

  sdram_cmd_arbiter #(.ASIZE(ASIZE), .WDOG_CYC(WDOG_CYC)) dut (
    .CLK(clk), .RESET_N(rst_n), .REQ(req), .REQ_WR(req_wr), .REQ_ADDR(req_addr),
    .INIT_REQ(init_req), .REF_REQ(ref_req), .CMD_ACK(cmd_ack),
    .CMD(cmd), .ADDR(addr), .ACK(ack), .GRANT_ID(gid), .BUSY(busy), .ERR(err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_grant(input int p, input logic wr);
    grant_t g;
    g.cmd  = wr ? 3'b010 : 3'b001;
    g.addr = port_addr[p];
    g.gid  = 2'(p);
    exp_grant_q.push_back(g);
  endtask

  task automatic expect_ack(input int p);
    logic [3:0] a;
    a = 4'b0001 << p;
    exp_ack_q.push_back(a);
  endtask

  // One clock: requesters drop REQ on ACK, controller model returns CMD_ACK.
  task automatic tick();
    @(posedge clk);
    #1;
    req = req & ~ack;
    if (cmd != 3'b000) issue_cyc++;
    else issue_cyc = 0;
    cmd_ack = (auto_ack && issue_cyc == ack_lat) || spur_ack;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 4'b0000; ref_req = 1'b0; init_req = 1'b0; spur_ack = 1'b0;
    auto_ack = 1'b1; ack_lat = 1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_req_clear(input string tag, input int bound);
    for (int i = 0; i < bound && req != 4'b0000; i++) tick();
    check_eq(tag, 32'(req), 32'd0);
    tick();
    tick();
  endtask

  // Monitor: score each new grant and each ACK pulse against the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (cmd != 3'b000 && prev_cmd == 3'b000) begin
        grant_cyc_q.push_back(cyc);
        if (exp_grant_q.size() == 0) begin
          check_eq("unexpected_grant_cmd", 32'(cmd), 32'd0);
        end else begin
          mon_g = exp_grant_q.pop_front();
          check_eq("grant_cmd", 32'(cmd), 32'(mon_g.cmd));
          check_eq("grant_addr", 32'(addr), 32'(mon_g.addr));
          check_eq("grant_id", 32'(gid), 32'(mon_g.gid));
          check_eq("grant_busy", 32'(busy), 32'd1);
        end
      end
      if (ack != 4'b0000) begin
        if (exp_ack_q.size() == 0) begin
          check_eq("unexpected_ack", 32'(ack), 32'd0);
        end else begin
          mon_a = exp_ack_q.pop_front();
          check_eq("ack_onehot", 32'(ack), 32'(mon_a));
          check_eq("ack_cmd_nop", 32'(cmd), 32'd0);
        end
      end
      prev_cmd = cmd;
      cyc++;
    end
  end

  initial begin
    #1000000;
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int n;
    port_addr[0] = 23'h012345;
    port_addr[1] = 23'h2A5A5A;
    port_addr[2] = 23'h70F0F0;
    port_addr[3] = 23'h7FFFFF;
    req_addr = {port_addr[3], port_addr[2], port_addr[1], port_addr[0]};
    rst_n = 1'b0; req = 4'b0000; req_wr = 4'b0000; init_req = 1'b0; ref_req = 1'b0; cmd_ack = 1'b0;

    // Reset values
    do_reset();
    check_eq("rst_cmd", 32'(cmd), 32'd0);
    check_eq("rst_addr", 32'(addr), 32'd0);
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_gid", 32'(gid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);

    // Single read, CMD_ACK after 4 ISSUE cycles
    ack_lat = 4;
    req_wr = 4'b0000;
    expect_grant(0, 1'b0);
    expect_ack(0);
    req = 4'b0001;
    tick();
    check_eq("rd_busy", 32'(busy), 32'd1);
    n = 0;
    while (cmd == 3'b001 && n < 20) begin
      n++;
      tick();
    end
    check_eq("rd_hold_cycles", 32'(n), 32'd4);
    check_eq("rd_ack", 32'(ack), 32'h1);
    check_eq("rd_cmd_nop", 32'(cmd), 32'd0);
    check_eq("rd_gid", 32'(gid), 32'd0);
    check_eq("rd_busy_low", 32'(busy), 32'd0);
    tick();
    check_eq("rd_ack_clear", 32'(ack), 32'd0);
    tick();

    // Round robin with all four ports, immediate CMD_ACK
    do_reset();
    req_wr = 4'b0101;
    for (int p = 0; p < 4; p++) begin
      expect_grant(p, req_wr[p]);
      expect_ack(p);
    end
    grant_cyc_q.delete();
    req = 4'b1111;
    wait_req_clear("rr_done", 40);
    check_eq("rr_grants", 32'(grant_cyc_q.size()), 32'd4);
    for (int i = 1; i < grant_cyc_q.size(); i++)
      check_eq("rr_spacing", 32'(grant_cyc_q[i] - grant_cyc_q[i-1]), 32'd3);

    // Refresh blocks grants in IDLE
    do_reset();
    ref_req = 1'b1;
    req_wr = 4'b0100;
    req = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("ref_cmd_nop", 32'(cmd), 32'd0);
      check_eq("ref_busy", 32'(busy), 32'd0);
    end
    expect_grant(2, 1'b1);
    expect_ack(2);
    ref_req = 1'b0;
    tick();
    check_eq("ref_release_cmd", 32'(cmd), 32'b010);
    check_eq("ref_release_gid", 32'(gid), 32'd2);
    wait_req_clear("ref_done", 20);

    // Init block with a stray CMD_ACK, then refresh rising during ISSUE
    do_reset();
    init_req = 1'b1;
    req_wr = 4'b0000;
    req = 4'b0010;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      spur_ack = (i == 20);
      tick();
      if (cmd != 3'b000) n++;
    end
    spur_ack = 1'b0;
    check_eq("init_no_grant", 32'(n), 32'd0);
    check_eq("init_no_ack", 32'(ack), 32'd0);
    ack_lat = 3;
    expect_grant(1, 1'b0);
    expect_ack(1);
    init_req = 1'b0;
    tick();
    check_eq("init_release_cmd", 32'(cmd), 32'b001);
    tick();
    ref_req = 1'b1;
    for (int i = 0; i < 20 && ack == 4'b0000; i++) tick();
    check_eq("midref_ack", 32'(ack), 32'b0010);
    tick();
    ref_req = 1'b0;
    tick();
    tick();

    // Reset while a write is in ISSUE
    do_reset();
    auto_ack = 1'b0;
    req_wr = 4'b0100;
    req = 4'b0100;
    expect_grant(2, 1'b1);
    tick();
    check_eq("abort_cmd_pre", 32'(cmd), 32'b010);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check_eq("abort_cmd", 32'(cmd), 32'd0);
    check_eq("abort_addr", 32'(addr), 32'd0);
    check_eq("abort_ack", 32'(ack), 32'd0);
    check_eq("abort_gid", 32'(gid), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    auto_ack = 1'b1;
    ack_lat = 2;
    req_wr = 4'b0000;
    req = 4'b1000;
    expect_grant(3, 1'b0);
    expect_ack(3);
    tick();
    check_eq("post_rst_gid3", 32'(gid), 32'd3);
    wait_req_clear("post_rst_p3_done", 20);
    do_reset();
    ack_lat = 1;
    for (int p = 0; p < 4; p++) begin
      expect_grant(p, 1'b0);
      expect_ack(p);
    end
    req = 4'b1111;
    tick();
    check_eq("post_rst_first_gid", 32'(gid), 32'd0);
    wait_req_clear("post_rst_all_done", 40);

`ifdef ARB_WATCHDOG_EN
    // Watchdog: no CMD_ACK, abort after WDOG_CYC ISSUE cycles
    do_reset();
    auto_ack = 1'b0;
    req_wr = 4'b0000;
    req = 4'b0001;
    expect_grant(0, 1'b0);
    tick();
    n = 0;
    while (cmd == 3'b001 && n < 40) begin
      n++;
      tick();
    end
    check_eq("wdog_cycles", 32'(n), 32'(WDOG_CYC));
    check_eq("wdog_err", 32'(err), 32'd1);
    check_eq("wdog_no_ack", 32'(ack), 32'd0);
    check_eq("wdog_busy", 32'(busy), 32'd0);
    expect_grant(0, 1'b0);
    expect_ack(0);
    auto_ack = 1'b1;
    ack_lat = 2;
    wait_req_clear("wdog_regrant_done", 20);
    check_eq("wdog_err_sticky", 32'(err), 32'd1);
`else
    check_eq("err_tied_low", 32'(err), 32'd0);
`endif

    tick();
    check_eq("grants_left", 32'(exp_grant_q.size()), 32'd0);
    check_eq("acks_left", 32'(exp_ack_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
